// File: rtl/sbox_share_sched.sv
// sbox_share_sched: shares one external 32-bit S-box slice between the AES-128
// state path (SubBytes, four column passes) and the key path (SubWord, one pass).
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   st_req/st_in    state SubBytes request (level) and 128-bit input
//   st_done/st_out  one-cycle completion pulse and held 128-bit result
//   kw_req/kw_in    key SubWord request (level) and 32-bit input
//   kw_done/kw_out  one-cycle completion pulse and held 32-bit result
//   sb_in/sb_out    drive to / combinational result from the shared S-box slice
//   busy            high while a job is running or completing
module sbox_share_sched (
   input  logic         clk,
   input  logic         rst,
   input  logic         st_req,
   input  logic [127:0] st_in,
   output logic         st_done,
   output logic [127:0] st_out,
   input  logic         kw_req,
   input  logic [31:0]  kw_in,
   output logic         kw_done,
   output logic [31:0]  kw_out,
   output logic [31:0]  sb_in,
   input  logic [31:0]  sb_out,
   output logic         busy
);

   localparam int unsigned BLK_W  = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned RES_W  = BLK_W - WORD_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ST_RUN = 2'd1,
      KW_RUN = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic                last_kw, last_kw_d;
   logic [BLK_W-1:0]    st_buf, st_buf_d;
   logic [WORD_W-1:0]   kw_buf, kw_buf_d;
   logic [RES_W-1:0]    res, res_d;
   logic [BLK_W-1:0]    st_out_d;
   logic [WORD_W-1:0]   kw_out_d;
   logic [WORD_W-1:0]   sb_in_d;
   logic                st_done_d, kw_done_d, busy_d;

   // Column select: column 0 is the most significant word.
   function automatic logic [WORD_W-1:0] col(input logic [BLK_W-1:0] b,
                                             input logic [CNT_W-1:0] i);
      logic [WORD_W-1:0] w;
      case (i)
         2'd0:    w = b[127:96];
         2'd1:    w = b[95:64];
         2'd2:    w = b[63:32];
         default: w = b[31:0];
      endcase
      return w;
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         last_kw <= 1'b0;
         st_buf  <= '0;
         kw_buf  <= '0;
         res     <= '0;
         st_out  <= '0;
         kw_out  <= '0;
         sb_in   <= '0;
         st_done <= 1'b0;
         kw_done <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         last_kw <= last_kw_d;
         st_buf  <= st_buf_d;
         kw_buf  <= kw_buf_d;
         res     <= res_d;
         st_out  <= st_out_d;
         kw_out  <= kw_out_d;
         sb_in   <= sb_in_d;
         st_done <= st_done_d;
         kw_done <= kw_done_d;
         busy    <= busy_d;
      end
   end

   // Next-state and next-output logic. sb_in is registered, so each branch
   // loads the word the S-box must see during the following cycle.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      last_kw_d = last_kw;
      st_buf_d  = st_buf;
      kw_buf_d  = kw_buf;
      res_d     = res;
      st_out_d  = st_out;
      kw_out_d  = kw_out;
      sb_in_d   = '0;
      st_done_d = 1'b0;
      kw_done_d = 1'b0;
      busy_d    = busy;

      case (state)
         IDLE: begin
            // Round robin on contention: state wins only if key went last.
            if (st_req && (!kw_req || last_kw)) begin
               st_buf_d  = st_in;
               cnt_d     = '0;
               last_kw_d = 1'b0;
               sb_in_d   = col(st_in, 2'd0);
               busy_d    = 1'b1;
               state_d   = ST_RUN;
            end else if (kw_req) begin
               kw_buf_d  = kw_in;
               last_kw_d = 1'b1;
               sb_in_d   = kw_in;
               busy_d    = 1'b1;
               state_d   = KW_RUN;
            end
         end

         ST_RUN: begin
            cnt_d = CNT_W'(cnt + 2'd1);
            case (cnt)
               2'd0: begin
                  res_d[95:64] = sb_out;
                  sb_in_d      = col(st_buf, 2'd1);
               end
               2'd1: begin
                  res_d[63:32] = sb_out;
                  sb_in_d      = col(st_buf, 2'd2);
               end
               2'd2: begin
                  res_d[31:0]  = sb_out;
                  sb_in_d      = col(st_buf, 2'd3);
               end
               default: begin
                  // Last column goes straight into the output word.
                  st_out_d  = {res, sb_out};
                  st_done_d = 1'b1;
                  state_d   = DONE;
               end
            endcase
         end

         KW_RUN: begin
            kw_out_d  = sb_out;
            kw_done_d = 1'b1;
            state_d   = DONE;
         end

         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sbox_share_sched.sv
// tb_sbox_share_sched: directed bench for sbox_share_sched. Supplies the shared
// S-box slice from a GF(2^8) reference, keeps a job-level timing model of the
// scheduler and compares every output on each falling edge, plus literal checks.
module tb_sbox_share_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         st_req;
   logic [127:0] st_in;
   logic         st_done;
   logic [127:0] st_out;
   logic         kw_req;
   logic [31:0]  kw_in;
   logic         kw_done;
   logic [31:0]  kw_out;
   logic [31:0]  sb_in;
   logic [31:0]  sb_out;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] SB_A   = 128'h638293c31bfc33f5c4eeacea4bc12816;
   localparam logic [31:0]  KW_A   = 32'h00010253;
   localparam logic [31:0]  SW_A   = 32'h637c77ed;

   sbox_share_sched dut (
      .clk     (clk),
      .rst     (rst),
      .st_req  (st_req),
      .st_in   (st_in),
      .st_done (st_done),
      .st_out  (st_out),
      .kw_req  (kw_req),
      .kw_in   (kw_in),
      .kw_done (kw_done),
      .kw_out  (kw_out),
      .sb_in   (sb_in),
      .sb_out  (sb_out),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // ---------------- S-box reference (inverse in GF(2^8) + affine) ----------
   function automatic logic [7:0] gmul(input logic [7:0] a_i, input logic [7:0] b_i);
      logic [7:0] a, b, p;
      logic hi;
      a = a_i; b = b_i; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
      logic [7:0] r;
      r = x;
      for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      if (x != 8'h00) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
      return r;
   endfunction

   function automatic logic [127:0] subbytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[32*i +: 32] = subword(s[32*i +: 32]);
      return r;
   endfunction

   // The external slice: purely combinational.
   always_comb sb_out = subword(sb_in);

   // ---------------- comparison helper ---------------------------------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- job-level model -----------------------------------------
   // A job is granted on an idle edge; cycle offsets after the grant decide
   // which column is on the slice, when done pulses and when the block is free.
   logic [127:0] e_st_out  = '0;
   logic [31:0]  e_kw_out  = '0;
   logic [31:0]  e_sb_in   = '0;
   logic         e_st_done = 1'b0;
   logic         e_kw_done = 1'b0;
   logic         e_busy    = 1'b0;
   int           m_t       = -1;
   bit           m_st      = 1'b0;
   bit           m_last_kw = 1'b0;
   logic [127:0] m_sv      = '0;
   logic [31:0]  m_kv      = '0;

   initial forever begin
      int len;
      @(posedge clk or posedge rst);
      if (rst) begin
         e_st_out = '0; e_kw_out = '0; e_sb_in = '0;
         e_st_done = 1'b0; e_kw_done = 1'b0; e_busy = 1'b0;
         m_t = -1; m_last_kw = 1'b0; m_sv = '0; m_kv = '0;
      end else begin
         e_st_done = 1'b0;
         e_kw_done = 1'b0;
         if (m_t < 0) begin
            if (st_req || kw_req) begin
               m_st      = st_req && !(kw_req && !m_last_kw);
               m_last_kw = !m_st;
               m_t       = 0;
               e_busy    = 1'b1;
               if (m_st) begin m_sv = st_in; e_sb_in = st_in[127:96]; end
               else      begin m_kv = kw_in; e_sb_in = kw_in;         end
            end
         end else begin
            m_t++;
            len = m_st ? 5 : 2;
            if (m_t == len) begin
               m_t = -1; e_busy = 1'b0; e_sb_in = '0;
            end else if (m_t == len - 1) begin
               e_sb_in = '0;
               if (m_st) begin e_st_out = subbytes(m_sv); e_st_done = 1'b1; end
               else      begin e_kw_out = subword(m_kv);  e_kw_done = 1'b1; end
            end else begin
               e_sb_in = m_sv[127 - 32*m_t -: 32];
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("st_done", 128'(st_done), 128'(e_st_done));
         chk("kw_done", 128'(kw_done), 128'(e_kw_done));
         chk("busy",    128'(busy),    128'(e_busy));
         chk("sb_in",   128'(sb_in),   128'(e_sb_in));
         chk("st_out",  st_out,        e_st_out);
         chk("kw_out",  128'(kw_out),  128'(e_kw_out));
      end
   end

   // ---------------- directed helpers ----------------------------------------
   // Counts falling edges until the selected done pulse; n==1 is the edge
   // right after the grant edge.
   task automatic wait_done(input bit want_st, input int lim, output int n,
                            output int b, output logic [31:0] sb1);
      bit hit;
      n = 0; b = 0; sb1 = '0; hit = 1'b0;
      while (!hit && n < lim) begin
         @(negedge clk);
         n++;
         if (busy) b++;
         if (n == 1) sb1 = sb_in;
         hit = want_st ? st_done : kw_done;
      end
      if (!hit) begin
         n_vec++; n_err++;
         $display("FAIL timeout waiting for %s done after %0d cycles", want_st ? "st" : "kw", n);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_st_out"},  st_out,         128'h0);
      chk({tag, "_kw_out"},  128'(kw_out),   128'h0);
      chk({tag, "_sb_in"},   128'(sb_in),    128'h0);
      chk({tag, "_busy"},    128'(busy),     128'h0);
      chk({tag, "_st_done"}, 128'(st_done),  128'h0);
      chk({tag, "_kw_done"}, 128'(kw_done),  128'h0);
   endtask

   // ---------------- stimulus -------------------------------------------------
   initial begin
      int n, b, cyc, nd;
      logic [31:0] sb1;
      bit   kinds [3];
      int   times [3];

      // watchdog-free: every wait below is bounded
      rst = 1'b1; st_req = 1'b0; kw_req = 1'b0; st_in = '0; kw_in = '0;
      repeat (2) @(negedge clk);

      // Model pins against hand-derived values.
      chk("model_subbytes", subbytes(PT_A), SB_A);
      chk("model_subword",  128'(subword(KW_A)), 128'(SW_A));
      chk("model_sbox_ff",  128'(sbox(8'hff)), 128'h16);

      chk_zero_outputs("reset");
      rst = 1'b0;
      cmp_en = 1'b1;
      @(negedge clk);

      // 1. State job.
      st_in = PT_A; st_req = 1'b1;
      wait_done(1'b1, 20, n, b, sb1);
      st_req = 1'b0;
      chk("st_latency", 128'(n), 128'(5));
      chk("st_busy_cycles", 128'(b), 128'(5));
      chk("st_first_col", 128'(sb1), 128'h00112233);
      chk("st_result", st_out, SB_A);
      @(negedge clk);
      chk("st_busy_clear", 128'(busy), 128'h0);

      // 2. Key job.
      kw_in = KW_A; kw_req = 1'b1;
      wait_done(1'b0, 20, n, b, sb1);
      kw_req = 1'b0;
      chk("kw_latency", 128'(n), 128'(2));
      chk("kw_sb_in", 128'(sb1), 128'(KW_A));
      chk("kw_result", 128'(kw_out), 128'(SW_A));
      chk("kw_done_sb_in", 128'(sb_in), 128'h0);
      repeat (2) @(negedge clk);

      // 3. Simultaneous requests from reset, held: K, S, K.
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      st_in = PT_A; kw_in = KW_A; st_req = 1'b1; kw_req = 1'b1;
      nd = 0; cyc = 0;
      while (nd < 3 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (st_done || kw_done) begin
            kinds[nd] = kw_done;
            times[nd] = cyc;
            nd++;
         end
      end
      st_req = 1'b0; kw_req = 1'b0;
      chk("alt_count", 128'(nd), 128'(3));
      if (nd == 3) begin
         chk("alt_first_kw",  128'(kinds[0]), 128'h1);
         chk("alt_second_st", 128'(kinds[1]), 128'h0);
         chk("alt_third_kw",  128'(kinds[2]), 128'h1);
         chk("alt_t0", 128'(times[0]), 128'(2));
         chk("alt_t1", 128'(times[1]), 128'(8));
         chk("alt_t2", 128'(times[2]), 128'(11));
      end
      chk("alt_st_out", st_out, SB_A);
      chk("alt_kw_out", 128'(kw_out), 128'(SW_A));
      repeat (2) @(negedge clk);

      // 4. No preemption: key request during state pass 2.
      st_in = 128'h0; kw_in = 32'hffffffff; st_req = 1'b1;
      repeat (3) @(negedge clk);
      kw_req = 1'b1;
      wait_done(1'b1, 20, n, b, sb1);
      st_req = 1'b0;
      chk("nopre_st_remaining", 128'(n), 128'(2));
      chk("nopre_st_out", st_out, {4{32'h63636363}});
      wait_done(1'b0, 20, n, b, sb1);
      kw_req = 1'b0;
      chk("nopre_kw_after", 128'(n), 128'(3));
      chk("nopre_kw_out", 128'(kw_out), 128'h16161616);
      repeat (2) @(negedge clk);

      // 5. Reset with cnt==2.
      st_in = PT_A; st_req = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_zero_outputs("midrst");
      @(negedge clk);
      chk_zero_outputs("midrst_hold");
      rst = 1'b0;
      wait_done(1'b1, 20, n, b, sb1);
      st_req = 1'b0;
      chk("midrst_regrant_latency", 128'(n), 128'(5));
      chk("midrst_st_out", st_out, SB_A);
      repeat (2) @(negedge clk);

      // 6. Input changed after grant.
      st_in = PT_A; st_req = 1'b1;
      @(negedge clk);
      st_in = 128'hffffffffffffffffffffffffffffffff;
      wait_done(1'b1, 20, n, b, sb1);
      st_req = 1'b0;
      chk("stable_st_out", st_out, SB_A);
      repeat (3) @(negedge clk);

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sbox_share_sched.md
# sbox_share_sched

Time-multiplexed scheduler that shares one 32-bit S-box slice (four external `sbox` instances) between two requesters in the AES-128 encryptor. The state path needs a full 128-bit SubBytes, done as four column passes. The key-expansion path needs a 32-bit SubWord, done as one pass. The block arbitrates between them, sequences the passes, collects the results and signals completion. It replaces the 16-instance SubBytes array in area-reduced builds.

## Interface
Parameters: none (widths fixed by AES-128).

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `st_req`  in  1  state SubBytes request, level; hold until `st_done`
- `st_in`  in  128  state input; byte 0 = bits [127:120]; sampled only at grant
- `st_done`  out  1  one-cycle pulse: `st_out` valid
- `st_out`  out  128  SubBytes(`st_in`), held until next state job completes
- `kw_req`  in  1  key SubWord request, level; hold until `kw_done`
- `kw_in`  in  32  SubWord input; sampled only at grant
- `kw_done`  out  1  one-cycle pulse: `kw_out` valid
- `kw_out`  out  32  SubWord(`kw_in`), held until next key job completes
- `sb_in`  out  32  to shared S-box slice
- `sb_out`  in  32  combinational S-box result of `sb_in`
- `busy`  out  1  high in ST_RUN, KW_RUN and DONE

## Operation
States: IDLE, ST_RUN, KW_RUN, DONE.

- **IDLE**
  - Only state in which requests are sampled.
  - One request high: grant it.
  - Both high: grant the requester not granted last (`last_kw` flag). Reset value favours key first.
  - Granting ST: latch `st_in` into `st_buf`, set `cnt=0`, go to ST_RUN.
  - Granting KW: latch `kw_in` into `kw_buf`, go to KW_RUN.
  - Update `last_kw` on every grant.
- **ST_RUN**
  - `sb_in = st_buf[127-32*cnt -: 32]`, so column 0 is bits [127:96].
  - Each edge: write `sb_out` into result word `cnt` and increment `cnt` (2-bit).
  - At the edge where `cnt==3`: copy the full result to `st_out`, set `st_done`, go to DONE.
- **KW_RUN**
  - `sb_in = kw_buf`.
  - Next edge: `kw_out <= sb_out`, set `kw_done`, go to DONE.
- **DONE**
  - One cycle with the done pulse high and `sb_in = 0`.
  - Go to IDLE unconditionally.
- Request changes while not in IDLE are ignored. There is no preemption: a key request arriving mid state job waits.
- A requester that keeps its req high after its done gets a new job from its re-sampled input at the next IDLE edge, subject to round-robin.
- `sb_in = 0` in IDLE and DONE.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0, `last_kw` = 0.
  - `st_done` = `kw_done` = `busy` = 0.
  - `st_out` = 0, `kw_out` = 0, `sb_in` = 0.
  - `st_buf` and `kw_buf` = 0.
- Grant edge E0 is the first IDLE edge with a request high.
- State job:
  - passes at E1..E4;
  - `st_done` high between E4 and E5;
  - IDLE again after E5;
  - earliest next grant at E6.
  - Latency is 4 cycles grant-to-done; throughput is 1 job per 6 cycles.
- Key job:
  - pass at E1;
  - `kw_done` high between E1 and E2;
  - earliest next grant at E3.
- `st_done` and `kw_done` are never high together, and never high for more than one cycle.
- `sb_out` is combinational in the same cycle. The S-box path must close within one clock.
- Reset asserted mid-job: the job is aborted immediately, no done pulse is issued, and the prior outputs are cleared to 0.

## Test plan
- **State job after reset:** `st_req=1`, `st_in=00112233445566778899aabbccddeeff`.
  - Required: `st_done` pulses exactly 4 cycles after grant.
  - `st_out=638293c31bfc33f5c4eeacea4bc12816`.
  - `busy` high for 5 cycles.
- **Key job:** `kw_req=1`, `kw_in=00010253`.
  - Required: `kw_done` pulses 1 cycle after grant.
  - `kw_out=637c77ed`.
  - `sb_in=00010253` during KW_RUN, and 0 otherwise.
- **Simultaneous requests from reset:** both requests high with the above data.
  - Required: key is granted first, `kw_done` pulses, then the state job is granted.
  - `st_done` pulses 7 cycles after the first grant, with the correct values.
  - Both requests held high: grants strictly alternate KW, ST, KW.
- **No preemption:** raise `kw_req` during ST_RUN pass 2.
  - Required: the state job completes unchanged, then the key is granted at the next IDLE edge.
- **Reset mid-job:** assert `rst` in ST_RUN with `cnt=2`.
  - Required: no `st_done` pulse, all outputs 0, state IDLE.
  - After release, the request is re-granted and `st_out` is correct.
- **Input stability:** change `st_in` after grant, during ST_RUN.
  - Required: the result reflects the value latched at grant.
